// File: rtl/conv_node_ctrl_if.sv
// conv_node_ctrl_if: window-in and result-out handshakes plus the shared conv_node control bus.
interface conv_node_ctrl_if #(
  parameter int KERNEL_HEIGHT = 3,
  parameter int KERNEL_WIDTH  = 2,
  parameter int NUM_WINDOWS   = 8
);
  localparam int K     = KERNEL_HEIGHT * KERNEL_WIDTH;
  localparam int IDX_W = $clog2(K + 1);
  localparam int WIN_W = NUM_WINDOWS > 1 ? $clog2(NUM_WINDOWS) : 1;
  logic             in_valid_i;
  logic             in_ready_o;
  logic             start_o;
  logic             ps_o;
  logic [IDX_W-1:0] input_index_o;
  logic             add_bias_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             last_o;
  logic [WIN_W-1:0] window_idx_o;
  logic             busy_o;
  modport master (
    input  in_valid_i, out_ready_i,
    output in_ready_o, start_o, ps_o, input_index_o, add_bias_o,
           out_valid_o, last_o, window_idx_o, busy_o
  );
  modport slave (
    output in_valid_i, out_ready_i,
    input  in_ready_o, start_o, ps_o, input_index_o, add_bias_o,
           out_valid_o, last_o, window_idx_o, busy_o
  );
endinterface

// File: rtl/conv_node_ctrl.sv
// conv_node_ctrl: sequences K MAC steps, a bias step and a latch pulse per window for a row of conv_nodes,
// then presents the result with a valid/ready handshake.
module conv_node_ctrl #(
  parameter int KERNEL_HEIGHT = 3,
  parameter int KERNEL_WIDTH  = 2,
  parameter int NUM_WINDOWS   = 8
) (
  input logic                clk_i,
  input logic                reset_n_i,
  conv_node_ctrl_if.master   bus
);
  localparam int K     = KERNEL_HEIGHT * KERNEL_WIDTH;
  localparam int IDX_W = $clog2(K + 1);
  localparam int WIN_W = NUM_WINDOWS > 1 ? $clog2(NUM_WINDOWS) : 1;
  typedef enum logic [2:0] {IDLE, MAC, BIAS, LATCH, OUT} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] step_q, step_d, index_q, index_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             ps_q, ps_d, bias_q, bias_d, start_q, start_d;
  logic             valid_q, valid_d, last_q, last_d, busy_q, busy_d;
  logic             out_hs;
  assign out_hs = state_q == OUT && bus.out_ready_i;
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        state_d = bus.in_valid_i ? MAC : IDLE;
        step_d  = '0;
      end
      MAC: begin
        state_d = step_q == IDX_W'(K - 1) ? BIAS : MAC;
        step_d  = step_q == IDX_W'(K - 1) ? '0 : step_q + 1'b1;
      end
      BIAS:  state_d = LATCH;
      LATCH: state_d = OUT;
      OUT: if (bus.out_ready_i) begin
        win_d   = win_q == WIN_W'(NUM_WINDOWS - 1) ? '0 : win_q + 1'b1;
        state_d = bus.in_valid_i ? MAC : IDLE;
        step_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they register in step with it.
    ps_d    = state_d == MAC || state_d == BIAS;
    bias_d  = state_d == BIAS;
    start_d = state_d == LATCH;
    valid_d = state_d == OUT;
    last_d  = state_d == OUT && win_d == WIN_W'(NUM_WINDOWS - 1);
    busy_d  = state_d != IDLE;
    index_d = state_d == MAC ? step_d : state_d == BIAS ? IDX_W'(K) : '0;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      step_q  <= '0;
      win_q   <= '0;
      index_q <= '0;
      ps_q    <= 1'b0;
      bias_q  <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      win_q   <= win_d;
      index_q <= index_d;
      ps_q    <= ps_d;
      bias_q  <= bias_d;
      start_q <= start_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end
  assign bus.in_ready_o    = state_q == IDLE || out_hs;
  assign bus.start_o       = start_q;
  assign bus.ps_o          = ps_q;
  assign bus.input_index_o = index_q;
  assign bus.add_bias_o    = bias_q;
  assign bus.out_valid_o   = valid_q;
  assign bus.last_o        = last_q;
  assign bus.window_idx_o  = win_q;
  assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_conv_node_ctrl.sv
// tb_conv_node_ctrl: drives random windows through the controller with a behavioural conv_node attached;
// a scoreboard queue of expected results is drained by an independent monitor.
module tb_conv_node_ctrl;
  localparam int K  = 6;
  localparam int NW = 8;
  typedef struct {int data; int win; int last; int edge_n;} exp_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  conv_node_ctrl_if bus();
  conv_node_ctrl dut (.clk_i(clk), .reset_n_i(rst_n), .bus(bus));
  exp_t sb[$];
  int   acc_edges[$];
  int   checks = 0, errors = 0;
  int   rom [K+1] = '{1, 2, 3, 4, 5, 6, 5};
  logic [7:0] win_in [K];
  logic [7:0] node_win [K];
  int   acc = 0, node_data = 0, ecount = 0, since_rst = 0;
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  function automatic int expect_sum(input logic [7:0] w [K]);
    int s = rom[K];
    for (int i = 0; i < K; i++) s += rom[i] * int'(w[i]);
    return s;
  endfunction
  always @(posedge clk) ecount <= ecount + 1;
  // Behavioural conv_node plus scoreboard push on each accepted window.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= 0;
      node_data <= 0;
      since_rst <= 0;
      sb.delete();
    end else begin
      if (bus.in_valid_i && bus.in_ready_o) begin
        node_win  <= win_in;
        sb.push_back('{data: expect_sum(win_in), win: since_rst % NW,
                       last: int'(since_rst % NW == NW - 1), edge_n: ecount});
        acc_edges.push_back(ecount);
        since_rst <= since_rst + 1;
      end
      if (bus.start_o) begin
        node_data <= acc;
        acc       <= 0;
      end else if (bus.ps_o)
        acc <= acc + (bus.add_bias_o ? rom[K] : rom[bus.input_index_o] * int'(node_win[bus.input_index_o]));
    end
  end
  initial begin
    bit hold = 0;
    int p_win, p_last, p_data;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        hold = 0;
        continue;
      end
      check("start_ps_excl", int'(bus.start_o && bus.ps_o), 0);
      if (bus.add_bias_o) check("bias_index", bus.input_index_o, K);
      if (hold) begin
        check("hold_valid", bus.out_valid_o, 1);
        check("hold_win", bus.window_idx_o, p_win);
        check("hold_last", bus.last_o, p_last);
        check("hold_data", node_data, p_data);
      end
      if (bus.out_valid_o) begin
        check("result_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          if (!hold) check("latency", ecount - sb[0].edge_n, K + 3);
          if (bus.out_ready_i) begin
            check("res_data", node_data, sb[0].data);
            check("res_win", bus.window_idx_o, sb[0].win);
            check("res_last", bus.last_o, sb[0].last);
            void'(sb.pop_front());
          end
        end
      end
      hold   = bus.out_valid_o && !bus.out_ready_i;
      p_win  = bus.window_idx_o;
      p_last = bus.last_o;
      p_data = node_data;
    end
  end
  task automatic rand_win();
    for (int i = 0; i < K; i++) win_in[i] = 8'($urandom);
  endtask
  task automatic wait_cond_ps3(output bit found);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #2;
      found = bus.ps_o && !bus.add_bias_o && bus.input_index_o == 3;
    end
  endtask
  initial begin
    bit found;
    int n0;
    bus.in_valid_i = 0;
    bus.out_ready_i = 1;
    rand_win();
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", bus.in_ready_o, 1);
    check("rst_ps", bus.ps_o, 0);
    check("rst_start", bus.start_o, 0);
    check("rst_valid", bus.out_valid_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_win", bus.window_idx_o, 0);
    @(negedge clk);
    rst_n = 1;
    // Single window: weights 1..6, data all 2, bias 5.
    @(negedge clk);
    for (int i = 0; i < K; i++) win_in[i] = 8'd2;
    bus.in_valid_i = 1;
    @(negedge clk);
    bus.in_valid_i = 0;
    for (int c = 1; c <= 9; c++) begin
      #1;
      check("t1_ps", bus.ps_o, int'(c <= 7));
      check("t1_idx", bus.input_index_o, c <= 6 ? c - 1 : c == 7 ? 6 : 0);
      check("t1_bias", bus.add_bias_o, int'(c == 7));
      check("t1_start", bus.start_o, int'(c == 8));
      check("t1_valid", bus.out_valid_o, int'(c == 9));
      if (c == 9) check("t1_data", node_data, 47);
      @(negedge clk);
    end
    // Backpressure: result held for 5 cycles while in_valid_i is ignored.
    bus.out_ready_i = 0;
    rand_win();
    bus.in_valid_i = 1;
    @(negedge clk);
    bus.in_valid_i = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      found = bus.out_valid_o;
    end
    check("bp_valid_seen", int'(found), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rand_win();
      bus.in_valid_i = 1;
      #1;
      check("bp_in_ready", bus.in_ready_o, 0);
      check("bp_busy", bus.busy_o, 1);
    end
    @(negedge clk);
    bus.in_valid_i = 0;
    bus.out_ready_i = 1;
    #1;
    check("bp_ready_comb", bus.in_ready_o, 1);
    @(negedge clk); #1;
    check("bp_done", bus.out_valid_o, 0);
    check("bp_win", bus.window_idx_o, 2);
    // Async reset mid-MAC.
    @(negedge clk);
    rand_win();
    bus.in_valid_i = 1;
    @(negedge clk);
    bus.in_valid_i = 0;
    wait_cond_ps3(found);
    check("rst_mac_found", int'(found), 1);
    rst_n = 0;
    #1;
    check("arst_ps", bus.ps_o, 0);
    check("arst_idx", bus.input_index_o, 0);
    check("arst_busy", bus.busy_o, 0);
    check("arst_win", bus.window_idx_o, 0);
    check("arst_in_ready", bus.in_ready_o, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rel_in_ready", bus.in_ready_o, 1);
    check("rel_win", bus.window_idx_o, 0);
    repeat (12) @(negedge clk);
    #1;
    check("rel_no_valid", bus.out_valid_o, 0);
    // Back-to-back stream of 9 windows: wrap and last.
    @(negedge clk);
    n0 = acc_edges.size();
    bus.out_ready_i = 1;
    bus.in_valid_i = 1;
    for (int i = 0; i < 200 && acc_edges.size() < n0 + 9; i++) begin
      rand_win();
      @(negedge clk);
    end
    bus.in_valid_i = 0;
    check("stream_count", acc_edges.size() - n0, 9);
    if (acc_edges.size() >= n0 + 9) check("stream_rate", acc_edges[n0 + 8] - acc_edges[n0], 8 * 9);
    for (int i = 0; i < 30 && (sb.size() != 0 || bus.busy_o); i++) @(negedge clk);
    check("stream_drain", sb.size(), 0);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rand_win();
      bus.in_valid_i = 1'($urandom_range(0, 1));
      bus.out_ready_i = $urandom_range(0, 3) != 0;
    end
    @(negedge clk);
    bus.in_valid_i = 0;
    bus.out_ready_i = 1;
    for (int i = 0; i < 40 && (sb.size() != 0 || bus.busy_o); i++) @(negedge clk);
    #2;
    check("final_drain", sb.size(), 0);
    check("final_idle", bus.busy_o, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
